csa_pipe: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor. It is the successor to the team's fixed 8-bit carry-select adder. Operands are split into SEG-bit segments. Each segment precomputes both carry-in outcomes and is selected by the carry from the segment below, with one pipeline stage per segment. A valid/ready handshake on both sides provides backpressure, so the block can sit between streaming datapath stages in the lab arithmetic units.

---
 rtl/csa_pipe_if.sv | 36 +++
 rtl/csa_pipe.sv | 116 +++++++++++
 tb/tb_csa_pipe.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_pipe_if.sv
// csa_pipe_if: operand/result handshake bundle for csa_pipe.
// master = upstream/downstream environment, slave = the adder pipeline.
// Optional: CSA_OVF_EN adds the signed-overflow flag ovf.
interface csa_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CSA_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
`ifdef CSA_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
`ifdef CSA_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/csa_pipe.sv
// csa_pipe: pipelined carry-select adder/subtractor.
// Operands are captured (b / carry-in inverted for subtract), then each
// SEG-bit segment is resolved by its own stage using the carry registered
// by the stage below. Valid/ready handshake with full-pipeline stall.
// Optional: CSA_OVF_EN adds a two's-complement overflow output (bus.ovf).
module csa_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic       clk,
    input logic       rst_n,
    csa_pipe_if.slave bus
);
    localparam int STAGES = (SEG >= 1) ? (WIDTH / SEG) : 1;

    generate
        if (SEG < 1) begin : g_bad_seg
            $error("csa_pipe: SEG must be at least 1");
        end else if ((WIDTH % SEG) != 0) begin : g_bad_width
            $error("csa_pipe: WIDTH must be a multiple of SEG");
        end
    endgenerate

    // Entry k holds the transaction about to have segment k resolved:
    // skewed operands, carry into segment k, and the lower result segments.
    logic [WIDTH-1:0]  opa  [STAGES];
    logic [WIDTH-1:0]  opb  [STAGES];
    logic [WIDTH-1:0]  part [STAGES];
    logic [STAGES-1:0] cy;
    logic [STAGES-1:0] vld;

    // Per-segment carry-select results.
    logic [SEG:0]      r0       [STAGES];
    logic [SEG:0]      r1       [STAGES];
    logic [WIDTH-1:0]  nxt_part [STAGES];
    logic [STAGES-1:0] sel_cy;

    // Output register.
    logic              out_v;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
`ifdef CSA_OVF_EN
    logic              ovf_q;
`endif

    logic              adv;

    assign adv           = !out_v || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_v;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef CSA_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

    // Each segment precomputes both carry-in outcomes; the incoming carry picks one.
    // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            r0[k]       = {1'b0, opa[k][k*SEG +: SEG]} + {1'b0, opb[k][k*SEG +: SEG]};
            r1[k]       = {1'b0, opa[k][k*SEG +: SEG]} + {1'b0, opb[k][k*SEG +: SEG]}
                          + {{SEG{1'b0}}, 1'b1};
            sel_cy[k]   = cy[k] ? r1[k][SEG] : r0[k][SEG];
            nxt_part[k] = part[k];
            nxt_part[k][k*SEG +: SEG] = cy[k] ? r1[k][SEG-1:0] : r0[k][SEG-1:0];
        end
    end

    // Control path: valid bits and the visible result, cleared by reset, frozen on stall.
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld    <= '0;
            out_v  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef CSA_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (adv) begin
            vld[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld[k] <= vld[k-1];
            end
            out_v <= vld[STAGES-1];
            if (vld[STAGES-1]) begin
                sum_q  <= nxt_part[STAGES-1];
                cout_q <= sel_cy[STAGES-1];
`ifdef CSA_OVF_EN
                ovf_q  <= (opa[STAGES-1][WIDTH-1] == opb[STAGES-1][WIDTH-1]) &&
                          (nxt_part[STAGES-1][WIDTH-1] != opa[STAGES-1][WIDTH-1]);
`endif
            end
        end
    end

    // Data path: operand capture and per-stage skew/result registers.
    // NOTE: these registers are not reset; their contents only matter under a set valid bit.
    always_ff @(posedge clk) begin
        if (adv) begin
            if (bus.in_valid) begin
                opa[0]  <= bus.a;
                opb[0]  <= bus.op_sub ? ~bus.b : bus.b;
                cy[0]   <= bus.op_sub ^ bus.cin;
                part[0] <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                opa[k]  <= opa[k-1];
                opb[k]  <= opb[k-1];
                cy[k]   <= sel_cy[k-1];
                part[k] <= nxt_part[k-1];
            end
        end
    end
endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe: scoreboard bench for csa_pipe (WIDTH=16, SEG=4).
// Expected results are queued at input transfer and compared at output transfer.
// Define CSA_OVF_EN to also check the overflow flag.
module tb_csa_pipe;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
        logic             lat_chk;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   cyc;
    int   n_rx;
    exp_t q[$];
    exp_t cur_exp;

    csa_pipe_if #(.WIDTH(WIDTH)) bus ();

    csa_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic v,
                                input logic lat);
        exp_t r;
        r.sum = s; r.cout = c; r.ovf = v; r.acc = 0; r.lat_chk = lat;
        return r;
    endfunction

    // Reference: plain integer arithmetic, borrow and signed range taken directly.
    function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                   input logic icin, input logic isub);
        logic [WIDTH:0] t;
        int             sr;
        exp_t           r;
        if (isub) begin
            t  = {1'b0, ia} - {1'b0, ib} - {{WIDTH{1'b0}}, icin};
            sr = int'($signed(ia)) - int'($signed(ib)) - int'(icin);
            r  = mk(t[WIDTH-1:0], ~t[WIDTH], 1'b0, 1'b0);
        end else begin
            t  = {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, icin};
            sr = int'($signed(ia)) + int'($signed(ib)) + int'(icin);
            r  = mk(t[WIDTH-1:0], t[WIDTH], 1'b0, 1'b0);
        end
        r.ovf = (sr > 32767) || (sr < -32768);
        return r;
    endfunction

    // Scoreboard: pop/compare on output transfer, push on input transfer; reset flushes.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
                end else if (bus.out_ready) begin
                    e = q.pop_front();
                    check("sum", {16'd0, bus.sum}, {16'd0, e.sum});
                    check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
`ifdef CSA_OVF_EN
                    check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
                    // Acceptance is sampled half a cycle before its edge, hence +1.
                    if (e.lat_chk) check("latency", cyc - e.acc, STAGES + 1);
                    n_rx++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e     = cur_exp;
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic icin, input logic isub, input exp_t e);
        int n;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a        = ia;
        bus.b        = ib;
        bus.cin      = icin;
        bus.op_sub   = isub;
        cur_exp      = e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        check("send_accept", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] sa [6];
        logic [WIDTH-1:0] sb [6];
        exp_t             first;
        int               rx0;
        int               n;
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;

        n_chk = 0; n_pass = 0; cyc = 0; n_rx = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b1;
        cur_exp       = mk(16'h0, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_sum", {16'd0, bus.sum}, 32'h0000);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed operations, each alone in the pipe, with latency check
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0, 1'b1)); idle(); drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1)); idle(); drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b1)); idle(); drain();
        send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b1)); idle(); drain();
        send(16'h1234, 16'h0234, 1'b1, 1'b1, mk(16'h0FFF, 1'b1, 1'b0, 1'b1)); idle(); drain();

        // Six back-to-back adds with a 3-cycle stall on the first result
        for (int i = 0; i < 6; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
        end
        first = model(sa[0], sb[0], 1'b0, 1'b0);
        rx0   = n_rx;
        fork
            begin
                for (int i = 0; i < 6; i++) send(sa[i], sb[i], 1'b0, 1'b0, model(sa[i], sb[i], 1'b0, 1'b0));
                idle();
            end
            begin
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!bus.out_valid && n < 50);
                check("stall_wait", {31'd0, bus.out_valid}, 32'd1);
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
                    check("stall_sum", {16'd0, bus.sum}, {16'd0, first.sum});
                    check("stall_cout", {31'd0, bus.cout}, {31'd0, first.cout});
                    check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_rx - rx0, 6);

        // Mixed random add/sub burst with bubbles
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
            if (i % 3 == 2) idle();
        end
        idle();
        drain();

        // Reset mid-flight: three ops discarded, next op has normal latency
        for (int i = 0; i < 3; i++) send(16'(i + 1), 16'h0101, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_sum", {16'd0, bus.sum}, 32'h0000);
        repeat (6) begin
            @(negedge clk);
            check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b1));
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
